serial_add_ctrl: RTL

Bit-serial addition controller that time-shares one external full_adder instance (ports i1, i2, cin -> sum, carry) to add two WIDTH-bit operands, LSB first, one bit per clock. It accepts a job over a valid/ready handshake, drives the full adder's inputs each cycle, and collects its sum and carry outputs. It presents the WIDTH-bit result and carry-out over a second valid/ready handshake. It sits between a requesting block and the shared full_adder datapath.

---
 rtl/serial_add_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: streams two WIDTH-bit operands LSB first through one
// shared external full adder and returns the registered sum and carry-out.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_i1,
    output logic             fa_i2,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_carry,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and the accepted data is sampled on that same edge.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic [CW-1:0]    cnt;
    logic             last_bit;

    assign last_bit = (cnt == CW'(WIDTH - 1));

    // New sum bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
    always_comb begin
        sum_next            = sum_sh >> 1;
        sum_next[WIDTH-1]   = fa_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        carry_q <= cin;
                        cnt     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum_sh  <= sum_next;
                    carry_q <= fa_carry;
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    if (last_bit) begin
                        sum_q  <= sum_next;
                        cout_q <= fa_carry;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign start_ready  = (state == IDLE);
    assign busy         = (state == RUN) || (state == DONE);
    assign result_valid = (state == DONE);
    assign sum          = sum_q;
    assign cout         = cout_q;

    // The full adder only sees live operand bits while a job is running.
    assign fa_i1  = (state == RUN) & a_sh[0];
    assign fa_i2  = (state == RUN) & b_sh[0];
    assign fa_cin = (state == RUN) & carry_q;

endmodule
